// File: rtl/branch_resolve_bht.sv
// Branch history table: 2-bit saturating direction predictor indexed by halfword PC bits.
// Latency: lookup is combinational; an accepted update is visible on the outputs one cycle later.
// Backpressure: none; every qualifying resolution is absorbed in the cycle it is presented.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   flush_i              invalidate every entry at the next edge
//   debug_mode_i         suppress table/counter updates (lookups continue)
//   vpc_i                fetch PC to predict
//   resolved_branch_i    resolution record from the branch unit
//   pred_valid_o/taken_o prediction for vpc_i
//   mispredict_cnt_o     accepted mispredicted branch resolutions (saturating)
//   update_cnt_o         accepted branch resolutions (saturating)

package config_pkg;
  typedef struct packed {
    logic [31:0] VLEN;
  } cva6_cfg_t;
  localparam cva6_cfg_t cva6_cfg_empty = '{VLEN: 32'd64};
endpackage

package riscv;
  localparam int unsigned VLEN = 64;
endpackage

package ariane_pkg;
  typedef enum logic [2:0] {
    NoCF   = 3'd0,
    Branch = 3'd1,
    Jump   = 3'd2,
    JumpR  = 3'd3,
    Return = 3'd4
  } cf_t;

  typedef struct packed {
    logic                   valid;
    logic [riscv::VLEN-1:0] pc;
    logic [riscv::VLEN-1:0] target_address;
    logic                   is_mispredict;
    logic                   is_taken;
    cf_t                    cf_type;
  } bp_resolve_t;
endpackage

module branch_resolve_bht #(
  parameter config_pkg::cva6_cfg_t CVA6Cfg    = config_pkg::cva6_cfg_empty,
  parameter int unsigned           NR_ENTRIES = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic                    debug_mode_i,
  input  logic [riscv::VLEN-1:0]  vpc_i,
  input  ariane_pkg::bp_resolve_t resolved_branch_i,
  output logic                    pred_valid_o,
  output logic                    pred_taken_o,
  output logic [31:0]             mispredict_cnt_o,
  output logic [31:0]             update_cnt_o
);

  localparam int unsigned IDXW = $clog2(NR_ENTRIES);

  logic [NR_ENTRIES-1:0] valid_q, valid_d;
  logic [1:0]            ctr_q [NR_ENTRIES];
  logic [1:0]            ctr_d [NR_ENTRIES];
  logic [31:0]           mis_cnt_q, mis_cnt_d;
  logic [31:0]           upd_cnt_q, upd_cnt_d;

  logic [IDXW-1:0] lkp_idx;
  logic [IDXW-1:0] upd_idx;
  logic            upd_accept;

  // Bit 0 is dropped so compressed and full-width instructions share one scheme.
  assign lkp_idx = vpc_i[IDXW:1];
  assign upd_idx = resolved_branch_i.pc[IDXW:1];

  assign upd_accept = resolved_branch_i.valid
                    && (resolved_branch_i.cf_type == ariane_pkg::Branch)
                    && !debug_mode_i
                    && !flush_i;

  // Lookup reads registered state only, so a same-cycle update is never bypassed.
  assign pred_valid_o     = valid_q[lkp_idx];
  assign pred_taken_o     = valid_q[lkp_idx] & ctr_q[lkp_idx][1];
  assign mispredict_cnt_o = mis_cnt_q;
  assign update_cnt_o     = upd_cnt_q;

  always_comb begin
    valid_d   = valid_q;
    ctr_d     = ctr_q;
    mis_cnt_d = mis_cnt_q;
    upd_cnt_d = upd_cnt_q;

    if (flush_i) begin
      // Counters are left stale; the valid bit alone decides whether they are trusted.
      valid_d = '0;
    end else if (upd_accept) begin
      if (!valid_q[upd_idx]) begin
        valid_d[upd_idx] = 1'b1;
        ctr_d[upd_idx]   = resolved_branch_i.is_taken ? 2'b10 : 2'b01;
      end else if (resolved_branch_i.is_taken) begin
        if (ctr_q[upd_idx] != 2'b11) ctr_d[upd_idx] = ctr_q[upd_idx] + 2'd1;
      end else begin
        if (ctr_q[upd_idx] != 2'b00) ctr_d[upd_idx] = ctr_q[upd_idx] - 2'd1;
      end
    end

    if (upd_accept) begin
      if (upd_cnt_q != 32'hFFFF_FFFF) upd_cnt_d = upd_cnt_q + 32'd1;
      if (resolved_branch_i.is_mispredict && (mis_cnt_q != 32'hFFFF_FFFF))
        mis_cnt_d = mis_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q   <= '0;
      mis_cnt_q <= '0;
      upd_cnt_q <= '0;
      for (int i = 0; i < NR_ENTRIES; i++) ctr_q[i] <= 2'b00;
    end else begin
      valid_q   <= valid_d;
      mis_cnt_q <= mis_cnt_d;
      upd_cnt_q <= upd_cnt_d;
      for (int i = 0; i < NR_ENTRIES; i++) ctr_q[i] <= ctr_d[i];
    end
  end

  // Fields not needed by a direction-only table.
  logic unused_bits;
  assign unused_bits = ^{CVA6Cfg, vpc_i[riscv::VLEN-1:IDXW+1], vpc_i[0],
                         resolved_branch_i.pc[riscv::VLEN-1:IDXW+1],
                         resolved_branch_i.pc[0], resolved_branch_i.target_address};

endmodule

// File: tb/tb_branch_resolve_bht.sv
module tb_branch_resolve_bht;

  logic                    clk_i;
  logic                    rst_ni;
  logic                    flush_i;
  logic                    debug_mode_i;
  logic [63:0]             vpc_i;
  ariane_pkg::bp_resolve_t resolved_branch_i;
  logic                    pred_valid_o;
  logic                    pred_taken_o;
  logic [31:0]             mispredict_cnt_o;
  logic [31:0]             update_cnt_o;

  int checks;
  int failures;

  branch_resolve_bht #(
    .CVA6Cfg   (config_pkg::cva6_cfg_empty),
    .NR_ENTRIES(64)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .flush_i          (flush_i),
    .debug_mode_i     (debug_mode_i),
    .vpc_i            (vpc_i),
    .resolved_branch_i(resolved_branch_i),
    .pred_valid_o     (pred_valid_o),
    .pred_taken_o     (pred_taken_o),
    .mispredict_cnt_o (mispredict_cnt_o),
    .update_cnt_o     (update_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Present one resolution for one clock edge, then withdraw it.
  task automatic do_update(input logic [63:0] pc, input logic taken, input logic mis,
                           input ariane_pkg::cf_t cf);
    resolved_branch_i.valid         = 1'b1;
    resolved_branch_i.pc            = pc;
    resolved_branch_i.target_address = pc + 64'h40;
    resolved_branch_i.is_taken      = taken;
    resolved_branch_i.is_mispredict = mis;
    resolved_branch_i.cf_type       = cf;
    step();
    resolved_branch_i.valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    flush_i = 1'b0;
    debug_mode_i = 1'b0;
    vpc_i = 64'h8000_0010;
    resolved_branch_i = '0;
    #12;
    checks++; if (pred_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", pred_valid_o); end
    checks++; if (pred_taken_o !== 1'b0) begin failures++; $display("FAIL reset_taken got=%b exp=0", pred_taken_o); end
    checks++; if (update_cnt_o !== 32'd0) begin failures++; $display("FAIL reset_upd_cnt got=%0d exp=0", update_cnt_o); end
    checks++; if (mispredict_cnt_o !== 32'd0) begin failures++; $display("FAIL reset_mis_cnt got=%0d exp=0", mispredict_cnt_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    step();
    checks++; if (pred_valid_o !== 1'b0) begin failures++; $display("FAIL post_reset_valid got=%b exp=0", pred_valid_o); end
  endtask

  task automatic test_taken_train();
    vpc_i = 64'h8000_0010;
    resolved_branch_i.valid    = 1'b1;
    resolved_branch_i.pc       = 64'h8000_0010;
    resolved_branch_i.is_taken = 1'b1;
    resolved_branch_i.is_mispredict = 1'b0;
    resolved_branch_i.cf_type  = ariane_pkg::Branch;
    #1;
    checks++; if (pred_valid_o !== 1'b0) begin failures++; $display("FAIL no_bypass_valid got=%b exp=0", pred_valid_o); end
    step();
    resolved_branch_i.valid = 1'b0;
    #1;
    checks++; if (pred_valid_o !== 1'b1) begin failures++; $display("FAIL first_taken_valid got=%b exp=1", pred_valid_o); end
    checks++; if (pred_taken_o !== 1'b1) begin failures++; $display("FAIL first_taken_taken got=%b exp=1", pred_taken_o); end
    checks++; if (update_cnt_o !== 32'd1) begin failures++; $display("FAIL first_upd_cnt got=%0d exp=1", update_cnt_o); end
    for (int i = 0; i < 3; i++) do_update(64'h8000_0010, 1'b1, 1'b0, ariane_pkg::Branch);
    checks++; if (pred_taken_o !== 1'b1) begin failures++; $display("FAIL four_taken_taken got=%b exp=1", pred_taken_o); end
    checks++; if (update_cnt_o !== 32'd4) begin failures++; $display("FAIL four_upd_cnt got=%0d exp=4", update_cnt_o); end
  endtask

  task automatic test_not_taken_mispredict();
    do_update(64'h8000_0010, 1'b0, 1'b1, ariane_pkg::Branch);   // 11 -> 10
    checks++; if (pred_taken_o !== 1'b1) begin failures++; $display("FAIL nt1_taken got=%b exp=1", pred_taken_o); end
    do_update(64'h8000_0010, 1'b0, 1'b1, ariane_pkg::Branch);   // 10 -> 01
    checks++; if (pred_taken_o !== 1'b0) begin failures++; $display("FAIL nt2_taken got=%b exp=0", pred_taken_o); end
    checks++; if (pred_valid_o !== 1'b1) begin failures++; $display("FAIL nt2_valid got=%b exp=1", pred_valid_o); end
    checks++; if (mispredict_cnt_o !== 32'd2) begin failures++; $display("FAIL nt_mis_cnt got=%0d exp=2", mispredict_cnt_o); end
    checks++; if (update_cnt_o !== 32'd6) begin failures++; $display("FAIL nt_upd_cnt got=%0d exp=6", update_cnt_o); end
  endtask

  task automatic test_saturate_low();
    do_update(64'h8000_0010, 1'b0, 1'b0, ariane_pkg::Branch);   // 01 -> 00
    do_update(64'h8000_0010, 1'b0, 1'b0, ariane_pkg::Branch);   // 00 stays
    do_update(64'h8000_0010, 1'b1, 1'b0, ariane_pkg::Branch);   // 00 -> 01
    checks++; if (pred_taken_o !== 1'b0) begin failures++; $display("FAIL sat_low_taken got=%b exp=0", pred_taken_o); end
    do_update(64'h8000_0010, 1'b1, 1'b0, ariane_pkg::Branch);   // 01 -> 10
    checks++; if (pred_taken_o !== 1'b1) begin failures++; $display("FAIL sat_low_recover got=%b exp=1", pred_taken_o); end
    checks++; if (update_cnt_o !== 32'd10) begin failures++; $display("FAIL sat_low_upd_cnt got=%0d exp=10", update_cnt_o); end
    checks++; if (mispredict_cnt_o !== 32'd2) begin failures++; $display("FAIL sat_low_mis_cnt got=%0d exp=2", mispredict_cnt_o); end
  endtask

  task automatic test_ignored_updates();
    do_update(64'h8000_0020, 1'b1, 1'b1, ariane_pkg::JumpR);
    vpc_i = 64'h8000_0020;
    #1;
    checks++; if (pred_valid_o !== 1'b0) begin failures++; $display("FAIL jumpr_valid got=%b exp=0", pred_valid_o); end
    checks++; if (update_cnt_o !== 32'd10) begin failures++; $display("FAIL jumpr_upd_cnt got=%0d exp=10", update_cnt_o); end
    debug_mode_i = 1'b1;
    do_update(64'h8000_0020, 1'b1, 1'b1, ariane_pkg::Branch);
    checks++; if (pred_valid_o !== 1'b0) begin failures++; $display("FAIL debug_valid got=%b exp=0", pred_valid_o); end
    checks++; if (update_cnt_o !== 32'd10) begin failures++; $display("FAIL debug_upd_cnt got=%0d exp=10", update_cnt_o); end
    checks++; if (mispredict_cnt_o !== 32'd2) begin failures++; $display("FAIL debug_mis_cnt got=%0d exp=2", mispredict_cnt_o); end
    vpc_i = 64'h8000_0010;
    #1;
    checks++; if (pred_taken_o !== 1'b1) begin failures++; $display("FAIL debug_lookup got=%b exp=1", pred_taken_o); end
    debug_mode_i = 1'b0;
  endtask

  task automatic test_alias();
    vpc_i = 64'h8000_0090;
    #1;
    checks++; if (pred_valid_o !== 1'b1) begin failures++; $display("FAIL alias_valid got=%b exp=1", pred_valid_o); end
    checks++; if (pred_taken_o !== 1'b1) begin failures++; $display("FAIL alias_taken got=%b exp=1", pred_taken_o); end
    vpc_i = 64'h8000_0011;
    #1;
    checks++; if (pred_taken_o !== 1'b1) begin failures++; $display("FAIL bit0_ignored got=%b exp=1", pred_taken_o); end
    vpc_i = 64'h8000_0012;
    #1;
    checks++; if (pred_valid_o !== 1'b0) begin failures++; $display("FAIL neighbor_valid got=%b exp=0", pred_valid_o); end
    vpc_i = 64'h8000_0010;
  endtask

  task automatic test_flush();
    flush_i = 1'b1;
    do_update(64'h8000_0010, 1'b1, 1'b1, ariane_pkg::Branch);
    flush_i = 1'b0;
    #1;
    checks++; if (pred_valid_o !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", pred_valid_o); end
    checks++; if (update_cnt_o !== 32'd10) begin failures++; $display("FAIL flush_upd_cnt got=%0d exp=10", update_cnt_o); end
    checks++; if (mispredict_cnt_o !== 32'd2) begin failures++; $display("FAIL flush_mis_cnt got=%0d exp=2", mispredict_cnt_o); end
    // Entry is invalid again, so a not-taken update reinitialises to weak NT.
    do_update(64'h8000_0010, 1'b0, 1'b0, ariane_pkg::Branch);
    checks++; if (pred_valid_o !== 1'b1) begin failures++; $display("FAIL refill_valid got=%b exp=1", pred_valid_o); end
    checks++; if (pred_taken_o !== 1'b0) begin failures++; $display("FAIL refill_taken got=%b exp=0", pred_taken_o); end
    checks++; if (update_cnt_o !== 32'd11) begin failures++; $display("FAIL refill_upd_cnt got=%0d exp=11", update_cnt_o); end
  endtask

  task automatic test_reset_mid_update();
    @(negedge clk_i);
    resolved_branch_i.valid    = 1'b1;
    resolved_branch_i.pc       = 64'h8000_0030;
    resolved_branch_i.is_taken = 1'b1;
    resolved_branch_i.is_mispredict = 1'b1;
    resolved_branch_i.cf_type  = ariane_pkg::Branch;
    #2;
    rst_ni = 1'b0;
    #1;
    checks++; if (update_cnt_o !== 32'd0) begin failures++; $display("FAIL async_reset_cnt got=%0d exp=0", update_cnt_o); end
    @(posedge clk_i);
    #1;
    resolved_branch_i.valid = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    vpc_i = 64'h8000_0030;
    step();
    checks++; if (pred_valid_o !== 1'b0) begin failures++; $display("FAIL mid_reset_valid got=%b exp=0", pred_valid_o); end
    checks++; if (mispredict_cnt_o !== 32'd0) begin failures++; $display("FAIL mid_reset_mis got=%0d exp=0", mispredict_cnt_o); end
    vpc_i = 64'h8000_0010;
    #1;
    checks++; if (pred_valid_o !== 1'b0) begin failures++; $display("FAIL mid_reset_old_entry got=%b exp=0", pred_valid_o); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_taken_train();
    test_not_taken_mispredict();
    test_saturate_low();
    test_ignored_updates();
    test_alias();
    test_flush();
    test_reset_mid_update();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_resolve_bht.md
BRANCH_RESOLVE_BHT -- requirements
Module: branch_resolve_bht

Interface
REQ-001 SHALL have parameter CVA6Cfg, default config_pkg::cva6_cfg_empty, meaning core configuration record.
REQ-002 SHALL have parameter NR_ENTRIES, default 64, meaning number of branch history entries (power of two, 2..1024).
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush_i  input  1  synchronous invalidate of all entries.
REQ-006 SHALL have port debug_mode_i  input  1  core in debug mode; table updates suppressed.
REQ-007 SHALL have port vpc_i  input  riscv::VLEN  fetch PC to be predicted.
REQ-008 SHALL have port resolved_branch_i  input  ariane_pkg::bp_resolve_t  resolution from the branch unit (valid, pc, target_address, is_mispredict, is_taken, cf_type).
REQ-009 SHALL have port pred_valid_o  output  1  table holds a valid entry for vpc_i.
REQ-010 SHALL have port pred_taken_o  output  1  predicted direction for vpc_i.
REQ-011 SHALL have port mispredict_cnt_o  output  32  count of accepted branch mispredict resolutions.
REQ-012 SHALL have port update_cnt_o  output  32  count of accepted branch updates.

Function
REQ-013 Index SHALL be pc[$clog2(NR_ENTRIES):1] (halfword granularity, bit 0 ignored); identical for lookup and update.
REQ-014 Each entry SHALL hold a valid bit and a 2-bit saturating counter (00 strong NT, 01 weak NT, 10 weak T, 11 strong T).
REQ-015 Lookup SHALL be combinational: pred_valid_o = entry valid, pred_taken_o = counter[1] when valid, else 0.
REQ-016 Update accepted iff resolved_branch_i.valid && cf_type == ariane_pkg::Branch && !debug_mode_i && !flush_i; all other cf_type values (NoCF, Jump, JumpR, Return) SHALL NOT modify the table.
REQ-017 Accepted update to an invalid entry SHALL write valid=1 and counter = is_taken ? 10 : 01.
REQ-018 Accepted update to a valid entry SHALL increment counter if is_taken, decrement if not, saturating at 11 and 00.
REQ-019 Update SHALL become visible on outputs the cycle after acceptance; same-cycle lookup of the updated index SHALL return the old state (no bypass).
REQ-020 flush_i SHALL clear all valid bits at the next edge; counters need not be cleared; flush has priority over a coincident update.
REQ-021 update_cnt_o SHALL increment by 1 per accepted update; mispredict_cnt_o SHALL increment by 1 per accepted update with is_mispredict=1.
REQ-022 Both counters SHALL saturate at 32'hFFFF_FFFF and SHALL NOT be cleared by flush_i.
REQ-023 Debug mode SHALL suppress table and counter updates only; lookups continue.

Reset
REQ-024 On rst_ni low, asynchronously: all valid bits 0, all counters 00, mispredict_cnt_o 0, update_cnt_o 0.
REQ-025 During and after reset until first update, pred_valid_o=0 and pred_taken_o=0 for every vpc_i.
REQ-026 Reset asserted mid-update SHALL discard that update; the table state SHALL be the reset state.

Verification
REQ-027 Reset, vpc_i=0x80000010 -> pred_valid_o=0, pred_taken_o=0, both counts 0.
REQ-028 Branch update pc=0x80000010 taken, then 3 more taken, lookup -> after 1st: valid=1,taken=1 (10); after 4th counter 11, update_cnt_o=4.
REQ-029 From counter 11 at pc=0x80000010: two not-taken updates with is_mispredict=1 -> taken=1 after 1st (10), taken=0 after 2nd (01), mispredict_cnt_o=2.
REQ-030 Update with cf_type=JumpR valid=1 at pc=0x80000020, and Branch update with debug_mode_i=1 -> table unchanged, counts unchanged.
REQ-031 flush_i=1 coincident with valid Branch update at pc=0x80000010 -> next cycle pred_valid_o=0 for that pc, update_cnt_o unchanged.
REQ-032 NR_ENTRIES=64: update pc=0x80000010 taken, lookup pc=0x80000090 (same index) -> valid=1, taken=1 (aliasing); lookup pc=0x80000011 -> same entry.
